// File: rtl/led_pattern_gen_if.sv
// -----------------------------------------------------------------------------
// led_pattern_gen_if
//   Board-side signal bundle of the iCEstick LED pattern generator.
//   btn        raw push button (active high, asynchronous, may bounce)
//   D1..D4     red ring LEDs, 1 = on
//   D5         centre green LED, 1 = on
//   mode       current animation mode: 0 CHASE, 1 BOUNCE, 2 COUNT, 3 ALL_ON
//   Modports:
//     master   the generator: samples btn, drives the LEDs and mode
//     slave    the board / environment: drives btn, observes LEDs and mode
// -----------------------------------------------------------------------------
interface led_pattern_gen_if;
   logic       btn;
   logic       D1;
   logic       D2;
   logic       D3;
   logic       D4;
   logic       D5;
   logic [1:0] mode;

   modport master (
      input  btn,
      output D1, D2, D3, D4, D5, mode
   );

   modport slave (
      output btn,
      input  D1, D2, D3, D4, D5, mode
   );
endinterface

// File: rtl/led_pattern_gen.sv
// -----------------------------------------------------------------------------
// led_pattern_gen
//   Animated patterns for the five iCEstick LEDs. A debounced push button
//   cycles through CHASE, BOUNCE, COUNT and ALL_ON; animation steps are paced by
//   a prescaler tick every DIV clocks.
//   Parameters:
//     DIV   clk cycles per animation step (>= 2)
//     DEB   clk cycles the button must be stable before it is accepted (>= 2)
//   Ports:
//     clk     system clock, rising edge
//     rstn    asynchronous active-low reset
//     bus_io  btn in; D1..D5 and mode out (all outputs are flops)
// -----------------------------------------------------------------------------
module led_pattern_gen #(
   parameter int unsigned DIV = 1_200_000,
   parameter int unsigned DEB = 120_000
) (
   input logic               clk,
   input logic               rstn,
   led_pattern_gen_if.master bus_io
);

   localparam int unsigned PsW = $clog2(DIV);
   localparam int unsigned DcW = $clog2(DEB);
   localparam logic [PsW-1:0] PsLast = PsW'(DIV - 1);
   localparam logic [DcW-1:0] DcLast = DcW'(DEB - 1);

   typedef enum logic [1:0] {
      ModeChase  = 2'd0,
      ModeBounce = 2'd1,
      ModeCount  = 2'd2,
      ModeAllOn  = 2'd3
   } mode_e;

   logic           btn_s1_q, btn_s2_q;
   logic           stable_q, stable_d;
   logic           stable_dly_q;
   logic [DcW-1:0] dc_q, dc_d;
   logic [PsW-1:0] ps_q, ps_d;
   mode_e          mode_q, mode_d;
   logic [1:0]     pos_q, pos_d;
   logic           dir_down_q, dir_down_d;
   logic [4:0]     cnt_q, cnt_d;
   logic           d5_tgl_q, d5_tgl_d;
   logic [4:0]     leds_q, leds_d;

   logic           adv;
   logic           tick;
   logic [3:0]     ring;

   always_comb begin
      // Debounce: any sample equal to the accepted level restarts the count.
      stable_d = stable_q;
      dc_d     = dc_q;
      if (btn_s2_q == stable_q) begin
         dc_d = '0;
      end else if (dc_q == DcLast) begin
         stable_d = btn_s2_q;
         dc_d     = '0;
      end else begin
         dc_d = dc_q + 1'b1;
      end

      adv  = stable_q & ~stable_dly_q;
      tick = (ps_q == PsLast);

      mode_d     = mode_q;
      pos_d      = pos_q;
      dir_down_d = dir_down_q;
      cnt_d      = cnt_q;
      d5_tgl_d   = d5_tgl_q;
      ps_d       = ps_q;

      if (adv) begin
         // Mode change restarts the animation; a coincident tick is dropped.
         mode_d     = mode_e'(mode_q + 2'd1);
         pos_d      = 2'd0;
         dir_down_d = 1'b0;
         cnt_d      = 5'd0;
         d5_tgl_d   = 1'b0;
         ps_d       = '0;
      end else begin
         ps_d = tick ? '0 : ps_q + 1'b1;
         if (tick) begin
            unique case (mode_q)
               ModeChase: begin
                  pos_d = pos_q + 2'd1;
                  if (pos_q == 2'd3) d5_tgl_d = ~d5_tgl_q;
               end
               ModeBounce: begin
                  if (!dir_down_q) begin
                     pos_d = pos_q + 2'd1;
                     if (pos_q == 2'd2) dir_down_d = 1'b1;
                  end else begin
                     pos_d = pos_q - 2'd1;
                     if (pos_q == 2'd1) dir_down_d = 1'b0;
                  end
               end
               ModeCount: cnt_d = cnt_q + 5'd1;
               default: ;
            endcase
         end
      end

      // LEDs are decoded from next state so they update on the same edge.
      ring   = 4'(4'b0001 << pos_d);
      leds_d = leds_q;
      unique case (mode_d)
         ModeChase:  leds_d = {d5_tgl_d, ring};
         ModeBounce: leds_d = {dir_down_d, ring};
         ModeCount:  leds_d = cnt_d;
         ModeAllOn:  leds_d = 5'b11111;
         default:    leds_d = 5'b00001;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         btn_s1_q     <= 1'b0;
         btn_s2_q     <= 1'b0;
         stable_q     <= 1'b0;
         stable_dly_q <= 1'b0;
         dc_q         <= '0;
         ps_q         <= '0;
         mode_q       <= ModeChase;
         pos_q        <= 2'd0;
         dir_down_q   <= 1'b0;
         cnt_q        <= 5'd0;
         d5_tgl_q     <= 1'b0;
         leds_q       <= 5'b00001;
      end else begin
         btn_s1_q     <= bus_io.btn;
         btn_s2_q     <= btn_s1_q;
         stable_q     <= stable_d;
         stable_dly_q <= stable_q;
         dc_q         <= dc_d;
         ps_q         <= ps_d;
         mode_q       <= mode_d;
         pos_q        <= pos_d;
         dir_down_q   <= dir_down_d;
         cnt_q        <= cnt_d;
         d5_tgl_q     <= d5_tgl_d;
         leds_q       <= leds_d;
      end
   end

   assign bus_io.D1   = leds_q[0];
   assign bus_io.D2   = leds_q[1];
   assign bus_io.D3   = leds_q[2];
   assign bus_io.D4   = leds_q[3];
   assign bus_io.D5   = leds_q[4];
   assign bus_io.mode = mode_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// -----------------------------------------------------------------------------
// tb_led_pattern_gen
//   Directed bench for led_pattern_gen with DIV=4, DEB=3. Inputs are driven and
//   outputs sampled on the falling clock edge; expected values are hand-derived.
// -----------------------------------------------------------------------------
module tb_led_pattern_gen;

   logic clk = 1'b0;
   logic rstn;
   int   tests = 0;
   int   fails = 0;

   led_pattern_gen_if u_if ();

   led_pattern_gen #(
      .DIV (4),
      .DEB (3)
   ) u_dut (
      .clk    (clk),
      .rstn   (rstn),
      .bus_io (u_if)
   );

   always #5 clk = ~clk;

   logic [4:0] leds;
   logic [4:0] mode5;
   assign leds  = {u_if.D5, u_if.D4, u_if.D3, u_if.D2, u_if.D1};
   assign mode5 = {3'b000, u_if.mode};

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   // Press held long enough to be accepted; mode is visible after 6 edges.
   task automatic press_release();
      u_if.btn = 1'b1;
      step(6);
   endtask

   initial begin
      u_if.btn = 1'b0;
      rstn     = 1'b1;
      #3 rstn  = 1'b0;
      step(2);
      chk("reset_leds", leds, 5'b00001);
      chk("reset_mode", mode5, 5'd0);
      rstn = 1'b1;

      // CHASE from reset: first step after 4 edges, D5 toggles at the 3->0 wrap.
      step(3);
      chk("chase_hold", leds, 5'b00001);
      step(1);
      chk("chase_pos1", leds, 5'b00010);
      step(12);
      chk("chase_wrap", leds, 5'b10001);

      // Short glitches are rejected and the animation runs on undisturbed.
      u_if.btn = 1'b1;
      step(1);
      u_if.btn = 1'b0;
      step(8);
      chk("glitch1_mode", mode5, 5'd0);
      chk("glitch1_leds", leds, 5'b10100);
      u_if.btn = 1'b1;
      step(2);
      u_if.btn = 1'b0;
      step(7);
      chk("glitch2_mode", mode5, 5'd0);
      chk("glitch2_leds", leds, 5'b00001);

      // Clean press held 20 clocks: one advance into BOUNCE, then 7 ticks.
      u_if.btn = 1'b1;
      step(5);
      chk("press_pre_adv", mode5, 5'd0);
      step(1);
      chk("press_mode1", mode5, 5'd1);
      chk("bounce_start", leds, 5'b00001);
      step(3);
      chk("bounce_hold", leds, 5'b00001);
      step(1);
      chk("bounce_t1", leds, 5'b00010);
      step(4);
      chk("bounce_t2", leds, 5'b00100);
      step(4);
      chk("bounce_t3", leds, 5'b11000);
      step(2);
      u_if.btn = 1'b0;
      step(2);
      chk("bounce_t4", leds, 5'b10100);
      step(4);
      chk("bounce_t5", leds, 5'b10010);
      step(4);
      chk("bounce_t6", leds, 5'b00001);
      step(4);
      chk("bounce_t7", leds, 5'b00010);
      chk("press_once", mode5, 5'd1);

      // Advance lands on the same cycle as a tick: COUNT starts at 0, no extra step.
      step(2);
      press_release();
      chk("coinc_mode", mode5, 5'd2);
      chk("coinc_leds", leds, 5'b00000);
      u_if.btn = 1'b0;
      for (int k = 1; k <= 33; k++) begin
         step(4);
         chk($sformatf("count_%0d", k), leds, 5'(k % 32));
      end

      // Four presses: 2 -> 3 -> 0 -> 1 -> 2.
      press_release();
      chk("wrap_mode3", mode5, 5'd3);
      chk("allon_leds", leds, 5'b11111);
      u_if.btn = 1'b0;
      step(6);
      press_release();
      chk("wrap_mode0", mode5, 5'd0);
      chk("wrap_ring", {1'b0, leds[3:0]}, 5'b00001);
      u_if.btn = 1'b0;
      step(6);
      press_release();
      chk("wrap_mode1", mode5, 5'd1);
      u_if.btn = 1'b0;
      step(6);
      press_release();
      chk("wrap_mode2", mode5, 5'd2);
      u_if.btn = 1'b0;
      step(6);
      step(9);
      chk("count_pre_rst", leds, 5'b00011);

      // Asynchronous reset mid-COUNT, then restart from the reset state.
      #2 rstn = 1'b0;
      #1;
      chk("async_rst_leds", leds, 5'b00001);
      chk("async_rst_mode", mode5, 5'd0);
      @(negedge clk);
      rstn = 1'b1;
      step(3);
      chk("restart_hold", leds, 5'b00001);
      step(1);
      chk("restart_pos1", leds, 5'b00010);
      chk("restart_mode", mode5, 5'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
